// File: rtl/axis_accel_pkg.sv
// Shared types and constants for the AXI-Stream frame accelerator bridge.
// Holds the FSM state encodings, default widths and a constant-safe clog2.
package axis_accel_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_NUM_IN_WORDS  = 32;
  localparam int DEF_NUM_OUT_WORDS = 1;
  localparam int DEF_CNT_WIDTH     = 16;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SEND  = 3'd4
  } bridge_state_e;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_e;

  // Returns ceil(log2(value)); usable in parameter context.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_frame_accel_bridge_if.sv
// Stream handshake bundle. A beat transfers on a cycle where valid && ready;
// the master holds data/last stable while valid is high and ready is low.
interface axis_frame_accel_bridge_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/axis_out_serializer.sv
// Captures the core result and emits it word by word on the output stream,
// pulsing done_o on the handshake of the final word.
module axis_out_serializer
  import axis_accel_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int NUM_OUT_WORDS = DEF_NUM_OUT_WORDS
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                load_i,
  input  logic [NUM_OUT_WORDS*DATA_WIDTH-1:0] result_i,
  axis_frame_accel_bridge_if.master           m_axis,
  output logic                                done_o
);

  localparam int RP_W = (NUM_OUT_WORDS > 1) ? clog2(NUM_OUT_WORDS) : 1;

  ser_state_e                          state_q, state_d;
  logic [NUM_OUT_WORDS*DATA_WIDTH-1:0] res_q, res_d;
  logic [RP_W-1:0]                     rp_q, rp_d;
  logic                                last_word;

  assign last_word = (rp_q == RP_W'(NUM_OUT_WORDS - 1));

  assign m_axis.valid = (state_q == SER_SEND);
  assign m_axis.last  = (state_q == SER_SEND) && last_word;
  assign m_axis.data  = res_q[int'(rp_q)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SER_IDLE;
      res_q   <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      rp_q    <= rp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    rp_d    = rp_q;
    done_o  = 1'b0;
    case (state_q)
      SER_IDLE: begin
        if (load_i) begin
          res_d   = result_i;
          rp_d    = '0;
          state_d = SER_SEND;
        end
      end
      SER_SEND: begin
        if (m_axis.ready) begin
          if (last_word) begin
            done_o  = 1'b1;
            rp_d    = '0;
            state_d = SER_IDLE;
          end else begin
            rp_d = rp_q + 1'b1;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

endmodule

// File: rtl/axis_frame_accel_bridge.sv
// Collects a fixed-length input frame from AXI-Stream, hands it to a compute
// core with a start pulse, and streams the core's result back out.
module axis_frame_accel_bridge
  import axis_accel_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int NUM_IN_WORDS  = DEF_NUM_IN_WORDS,
  parameter int NUM_OUT_WORDS = DEF_NUM_OUT_WORDS,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                                axi_clk,
  input  logic                                axi_reset_n,
  input  logic [DATA_WIDTH-1:0]               s_axis_data,
  input  logic                                s_axis_valid,
  output logic                                s_axis_ready,
  input  logic                                s_axis_last,
  output logic [DATA_WIDTH-1:0]               m_axis_data,
  output logic                                m_axis_valid,
  input  logic                                m_axis_ready,
  output logic                                m_axis_last,
  output logic [NUM_IN_WORDS*DATA_WIDTH-1:0]  core_img,
  output logic                                core_start,
  input  logic                                core_done,
  input  logic [NUM_OUT_WORDS*DATA_WIDTH-1:0] core_result,
  output logic [CNT_WIDTH-1:0]                frame_count,
  output logic                                err_short,
  output logic                                err_long,
  output logic                                busy
);

  localparam int WP_W = clog2(NUM_IN_WORDS);

  bridge_state_e         state_q, state_d;
  logic [WP_W-1:0]       wp_q, wp_d;
  logic [NUM_IN_WORDS-1:0] mask_q, mask_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_short_q, err_short_d;
  logic                  err_long_q, err_long_d;
  logic [DATA_WIDTH-1:0] frame_q [NUM_IN_WORDS];

  logic in_hs;
  logic at_end;
  logic wr_en;
  logic ser_load;
  logic ser_done;

  assign s_axis_ready = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign in_hs        = s_axis_valid && s_axis_ready;
  assign at_end       = (wp_q == WP_W'(NUM_IN_WORDS - 1));
  assign busy         = (state_q != ST_LOAD);
  assign frame_count  = cnt_q;
  assign err_short    = err_short_q;
  assign err_long     = err_long_q;

  // Unwritten slots read as zero, so stale data from a previous frame never leaks.
  for (genvar j = 0; j < NUM_IN_WORDS; j++) begin : g_img
    assign core_img[j*DATA_WIDTH +: DATA_WIDTH] = mask_q[j] ? frame_q[j] : '0;
  end

  always_ff @(posedge axi_clk) begin
    if (wr_en) frame_q[wp_q] <= s_axis_data;
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q     <= ST_LOAD;
      wp_q        <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    wr_en       = 1'b0;
    ser_load    = 1'b0;
    core_start  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (in_hs) begin
          wr_en        = 1'b1;
          mask_d[wp_q] = 1'b1;
          if (at_end) begin
            // A full buffer without last means the sender overran; drop the rest.
            state_d    = s_axis_last ? ST_START : ST_DRAIN;
            err_long_d = err_long_q | !s_axis_last;
          end else if (s_axis_last) begin
            err_short_d = 1'b1;
            state_d     = ST_START;
          end else begin
            wp_d = wp_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (in_hs && s_axis_last) state_d = ST_START;
      end
      ST_START: begin
        core_start = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          ser_load = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ser_done) begin
          cnt_d   = cnt_q + 1'b1;
          mask_d  = '0;
          wp_d    = '0;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  axis_frame_accel_bridge_if #(.DATA_WIDTH(DATA_WIDTH)) out_if ();

  assign out_if.ready = m_axis_ready;
  assign m_axis_data  = out_if.data;
  assign m_axis_valid = out_if.valid;
  assign m_axis_last  = out_if.last;

  axis_out_serializer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .NUM_OUT_WORDS (NUM_OUT_WORDS)
  ) u_out_serializer (
    .clk_i    (axi_clk),
    .rst_ni   (axi_reset_n),
    .load_i   (ser_load),
    .result_i (core_result),
    .m_axis   (out_if.master),
    .done_o   (ser_done)
  );

endmodule

// File: tb/tb_axis_frame_accel_bridge.sv
// Self-checking bench for axis_frame_accel_bridge: random frames of varying
// length against a frame-level model of image, error flags, result order and count.
module tb_axis_frame_accel_bridge;

  localparam int DW   = 32;
  localparam int NIN  = 32;
  localparam int NOUT = 4;
  localparam int CW   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  axis_frame_accel_bridge_if #(.DATA_WIDTH(DW)) s_if ();
  axis_frame_accel_bridge_if #(.DATA_WIDTH(DW)) m_if ();

  logic [NIN*DW-1:0]  core_img;
  logic               core_start;
  logic               core_done;
  logic [NOUT*DW-1:0] core_result;
  logic [CW-1:0]      frame_count;
  logic               err_short;
  logic               err_long;
  logic               busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0]     exp_q[$];
  logic [NIN*DW-1:0] exp_img;
  logic              exp_es;
  logic              exp_el;
  int                exp_frames;

  axis_frame_accel_bridge #(
    .DATA_WIDTH    (DW),
    .NUM_IN_WORDS  (NIN),
    .NUM_OUT_WORDS (NOUT),
    .CNT_WIDTH     (CW)
  ) dut (
    .axi_clk      (clk),
    .axi_reset_n  (rst_n),
    .s_axis_data  (s_if.data),
    .s_axis_valid (s_if.valid),
    .s_axis_ready (s_if.ready),
    .s_axis_last  (s_if.last),
    .m_axis_data  (m_if.data),
    .m_axis_valid (m_if.valid),
    .m_axis_ready (m_if.ready),
    .m_axis_last  (m_if.last),
    .core_img     (core_img),
    .core_start   (core_start),
    .core_done    (core_done),
    .core_result  (core_result),
    .frame_count  (frame_count),
    .err_short    (err_short),
    .err_long     (err_long),
    .busy         (busy)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Asynchronous reset applied off the clock edge; checks every reset-forced output.
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (frame_count !== '0 || err_short !== 1'b0 || err_long !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: count=%0d es=%b el=%b busy=%b want 0 0 0 0",
               frame_count, err_short, err_long, busy);
    end
    n_cmp++;
    if (core_start !== 1'b0 || m_if.valid !== 1'b0 || m_if.last !== 1'b0 ||
        m_if.data !== '0 || core_img !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: start=%b mvalid=%b mlast=%b mdata=%h img_nonzero=%b want all 0",
               core_start, m_if.valid, m_if.last, m_if.data, (core_img != '0));
    end
    s_if.valid  = 1'b0;
    s_if.last   = 1'b0;
    m_if.ready  = 1'b0;
    core_done   = 1'b0;
    exp_es      = 1'b0;
    exp_el      = 1'b0;
    exp_frames  = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (s_if.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", s_if.ready);
    end
    @(posedge clk);
    #1;
  endtask

  // Sends an n-word frame; ends at the negedge of the cycle that must carry core_start.
  task automatic load_frame(input int n, input bit seq);
    logic [DW-1:0] w;
    exp_img = '0;
    for (int i = 0; i < n; i++) begin
      if (!seq && $urandom_range(0, 3) == 0) begin
        s_if.valid = 1'b0;
        @(posedge clk);
        #1;
      end
      w = seq ? DW'(i + 1) : DW'($urandom);
      if (i < NIN) exp_img[i*DW +: DW] = w;
      s_if.data  = w;
      s_if.valid = 1'b1;
      s_if.last  = (i == n - 1);
      @(negedge clk);
      n_cmp++;
      if (s_if.ready !== 1'b1 || busy !== (i >= NIN)) begin
        n_fail++;
        $display("FAIL in_beat%0d: ready=%b busy=%b want ready=1 busy=%b",
                 i, s_if.ready, busy, (i >= NIN));
      end
      @(posedge clk);
      #1;
    end
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    if (n < NIN) exp_es = 1'b1;
    if (n > NIN) exp_el = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (core_start !== 1'b1 || s_if.ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_pulse: start=%b ready=%b busy=%b want 1 0 1",
               core_start, s_if.ready, busy);
    end
    n_cmp++;
    if (core_img !== exp_img) begin
      n_fail++;
      $display("FAIL core_img: got %h want %h", core_img, exp_img);
    end
    n_cmp++;
    if (err_short !== exp_es || err_long !== exp_el) begin
      n_fail++;
      $display("FAIL err_flags: es=%b el=%b want es=%b el=%b", err_short, err_long, exp_es, exp_el);
    end
  endtask

  // Waits `delay` cycles in WAIT, fires core_done, then drains the result words.
  task automatic finish_frame(input int delay, input bit use_pat);
    bit [3:0]      pat;
    int            cyc;
    logic [CW-1:0] exp_cnt;
    pat = 4'b1001;
    for (int c = 0; c < delay; c++) begin
      @(negedge clk);
      n_cmp++;
      if (core_start !== 1'b0 || m_if.valid !== 1'b0 || s_if.ready !== 1'b0 || core_img !== exp_img) begin
        n_fail++;
        $display("FAIL wait_cycle%0d: start=%b mvalid=%b ready=%b img_ok=%b want 0 0 0 1",
                 c, core_start, m_if.valid, s_if.ready, (core_img === exp_img));
      end
    end
    for (int k = 0; k < NOUT; k++) core_result[k*DW +: DW] = DW'($urandom);
    for (int k = 0; k < NOUT; k++) exp_q.push_back(core_result[k*DW +: DW]);
    core_done = 1'b1;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 64) begin
      m_if.ready = (use_pat && cyc < 4) ? pat[3-cyc] : 1'($urandom_range(0, 1));
      @(negedge clk);
      n_cmp++;
      if (m_if.valid !== 1'b1 || m_if.data !== exp_q[0] || m_if.last !== (exp_q.size() == 1)) begin
        n_fail++;
        $display("FAIL out_word%0d: valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                 NOUT - exp_q.size(), m_if.valid, m_if.data, m_if.last, exp_q[0], (exp_q.size() == 1));
      end
      if (m_if.ready) void'(exp_q.pop_front());
      @(posedge clk);
      #1;
      cyc++;
    end
    m_if.ready = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL out_timeout: %0d words left want 0", exp_q.size());
      exp_q.delete();
    end
    exp_frames++;
    exp_cnt = CW'(exp_frames % (1 << CW));
    @(negedge clk);
    n_cmp++;
    if (s_if.ready !== 1'b1 || busy !== 1'b0 || m_if.valid !== 1'b0 || frame_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL frame_end: ready=%b busy=%b mvalid=%b count=%0d want 1 0 0 %0d",
               s_if.ready, busy, m_if.valid, frame_count, exp_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_full_frame();
    load_frame(NIN, 1'b1);
    finish_frame(5, 1'b0);
  endtask

  task automatic test_short_frame();
    load_frame(10, 1'b0);
    finish_frame($urandom_range(1, 6), 1'b0);
  endtask

  task automatic test_long_frame();
    load_frame(40, 1'b0);
    finish_frame($urandom_range(1, 6), 1'b0);
  endtask

  task automatic test_out_stall();
    load_frame(NIN, 1'b0);
    finish_frame(3, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      load_frame($urandom_range(2, 40), 1'b0);
      finish_frame($urandom_range(1, 4), 1'b0);
    end
  endtask

  task automatic test_reset_in_wait();
    load_frame(NIN, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    apply_reset();
    load_frame(NIN, 1'b1);
    finish_frame(5, 1'b0);
  endtask

  task automatic test_count_wrap();
    apply_reset();
    for (int f = 0; f < 5; f++) begin
      load_frame(NIN, 1'b0);
      finish_frame($urandom_range(1, 4), 1'b0);
    end
    n_cmp++;
    if (frame_count !== 2'd1) begin
      n_fail++;
      $display("FAIL count_wrap: got %0d want 1", frame_count);
    end
  endtask

  initial begin
    s_if.data   = '0;
    s_if.valid  = 1'b0;
    s_if.last   = 1'b0;
    m_if.ready  = 1'b0;
    core_done   = 1'b0;
    core_result = '0;
    exp_img     = '0;
    exp_es      = 1'b0;
    exp_el      = 1'b0;
    exp_frames  = 0;
    test_reset();
    test_full_frame();
    test_short_frame();
    test_long_frame();
    test_out_stall();
    test_back_to_back();
    test_reset_in_wait();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_frame_accel_bridge.md
AXIS_FRAME_ACCEL_BRIDGE -- requirements
Module: axis_frame_accel_bridge

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 32, as the stream and core word width.
REQ-002 SHALL take parameter NUM_IN_WORDS, default 32, as the input frame length in words (≥2).
REQ-003 SHALL take parameter NUM_OUT_WORDS, default 1, as the result length in words (≥1).
REQ-004 SHALL take parameter CNT_WIDTH, default 16, as the frame_count width.
REQ-005 SHALL have ports, in this order:
- axi_clk  in  1  sole clock
- axi_reset_n  in  1  reset (see REQ-006)
- s_axis_data  in  DATA_WIDTH  input word
- s_axis_valid  in  1  input valid
- s_axis_ready  out  1  input ready
- s_axis_last  in  1  last word of input frame
- m_axis_data  out  DATA_WIDTH  result word
- m_axis_valid  out  1  result valid
- m_axis_ready  in  1  result ready
- m_axis_last  out  1  last result word
- core_img  out  NUM_IN_WORDS*DATA_WIDTH  frame to core, word j at bits [j*DATA_WIDTH +: DATA_WIDTH]
- core_start  out  1  one-cycle start pulse
- core_done  in  1  core result valid
- core_result  in  NUM_OUT_WORDS*DATA_WIDTH  core result, same packing as core_img
- frame_count  out  CNT_WIDTH  completed frames
- err_short  out  1  sticky: frame ended early
- err_long  out  1  sticky: frame overran
- busy  out  1  high in any state other than LOAD
REQ-006 SHALL use one clock, axi_clk; reset axi_reset_n is asynchronous and active-low.

Function
REQ-007 SHALL use FSM states LOAD (reset state), DRAIN, START, WAIT, SEND.
REQ-008 LOAD: s_axis_ready=1; each handshake writes buf[wp] and sets mask[wp]; wp increments.
REQ-009 LOAD exits on a handshake with s_axis_last=1 or with wp==NUM_IN_WORDS-1, whichever comes first.
REQ-010 Exit on last with wp<NUM_IN_WORDS-1 SHALL set err_short and go to START; unwritten words present as zero on core_img.
REQ-011 Exit at wp==NUM_IN_WORDS-1 with last=0 SHALL set err_long and go to DRAIN.
REQ-012 Exit at wp==NUM_IN_WORDS-1 with last=1 SHALL go to START with no error.
REQ-013 DRAIN: s_axis_ready=1; beats are discarded; a handshake with last=1 goes to START.
REQ-014 START SHALL last exactly one cycle with core_start=1, then go to WAIT.
REQ-015 core_img SHALL equal the masked buffer and stay stable from START through the end of WAIT.
REQ-016 WAIT: core_done is sampled only in WAIT; on core_done, latch core_result into the output register, reset rp=0, go to SEND.
REQ-017 SEND: m_axis_valid=1; m_axis_data=out word rp; m_axis_last=1 iff rp==NUM_OUT_WORDS-1.
REQ-018 SEND: rp advances only on m_axis_valid && m_axis_ready; data and last SHALL stay stable while valid && !ready.
REQ-019 The last-word output handshake SHALL increment frame_count (wraps modulo 2^CNT_WIDTH), clear mask and wp, and return to LOAD.
REQ-020 s_axis_ready SHALL be 0 in START, WAIT and SEND.
REQ-021 Latency: final input handshake at cycle t gives core_start at t+1; core_done at d gives m_axis_valid at d+1; final output handshake gives s_axis_ready=1 at the next cycle.
REQ-022 err_short and err_long SHALL clear only on reset.

Reset
REQ-023 Asserting axi_reset_n=0 at any time, including mid-frame, SHALL asynchronously force LOAD, wp=rp=0, mask=0, all error and status flags 0, frame_count=0, and core_start=m_axis_valid=m_axis_last=0.
REQ-024 After reset, m_axis_data=0, core_img=0 and busy=0; the first cycle after deassertion SHALL have s_axis_ready=1.

Structure
REQ-025 Package axis_accel_pkg SHALL hold the FSM state enum, a clog2 function, and default width constants.
REQ-026 Output sequencing (result register, rp, valid/last) SHALL be a sub-module, axis_out_serializer.

Verification
REQ-027 32 words 1..32, last on word 32, core_done 5 cycles after start -> core_img word j=j+1, m_axis_data=core_result, last=1, frame_count=1, no errors.
REQ-028 Frame of 10 words with last on word 10 -> err_short=1, core_img words 10..31 = 0, core_start at t+1.
REQ-029 Frame of 40 words, last on word 40 -> words 33..40 discarded, err_long=1, core_start the cycle after beat 40.
REQ-030 NUM_OUT_WORDS=4, m_axis_ready toggled 1-0-0-1 -> four words in order, held stable while stalled, last only on word 4.
REQ-031 Reset asserted in WAIT, then a clean frame -> all outputs 0 during reset, frame_count=1 after the clean frame.
REQ-032 CNT_WIDTH=2, 5 frames -> frame_count=1 (wrapped).
